// File: rtl/gpio_pad_bank_if.sv
// Pad-bank control/status bundle between the register side (master) and gpio_pad_bank (slave).
interface gpio_pad_bank_if #(
   parameter int unsigned CH_NUM   = 8,
   parameter int unsigned DB_WIDTH = 8
);
   logic [CH_NUM-1:0]   dir_i;
   logic [CH_NUM-1:0]   out_i;
   logic [CH_NUM-1:0]   pull_en_i;
   logic [DB_WIDTH-1:0] db_thr_i;
   logic [CH_NUM-1:0]   irq_rise_en_i;
   logic [CH_NUM-1:0]   irq_fall_en_i;
   logic [CH_NUM-1:0]   irq_clr_i;
   logic [CH_NUM-1:0]   pad_in_i;
   logic [CH_NUM-1:0]   pad_out_o;
   logic [CH_NUM-1:0]   pad_oen_o;
   logic [CH_NUM-1:0]   pad_ren_o;
   logic [CH_NUM-1:0]   in_o;
   logic [CH_NUM-1:0]   irq_o;
   logic                irq_any_o;

   modport master (
      output dir_i, out_i, pull_en_i, db_thr_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_in_i,
      input  pad_out_o, pad_oen_o, pad_ren_o, in_o, irq_o, irq_any_o
   );

   modport slave (
      input  dir_i, out_i, pull_en_i, db_thr_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_in_i,
      output pad_out_o, pad_oen_o, pad_ren_o, in_o, irq_o, irq_any_o
   );
endinterface

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: registered pad drivers, 2-flop input sync, optional debounce, sticky edge IRQs.
// Debounce counters are built only when GPIO_PAD_BANK_DEBOUNCE_EN is defined.
module gpio_pad_bank #(
   parameter int unsigned CH_NUM   = 8,
   parameter int unsigned DB_WIDTH = 8
) (
   input logic             clk_i,
   input logic             rst_n_i,
   gpio_pad_bank_if.slave  bus
);

   logic [CH_NUM-1:0] pad_out_q, pad_oen_q, pad_ren_q;
   logic [CH_NUM-1:0] s1_q, s2_q;
   logic [CH_NUM-1:0] in_q, in_d;
   logic [CH_NUM-1:0] irq_q, irq_d;

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
   logic [DB_WIDTH-1:0] cnt_q [CH_NUM];
   logic [DB_WIDTH-1:0] cnt_d [CH_NUM];

   // Accept s2 only after it has disagreed with in_o for db_thr_i+1 consecutive edges.
   always_comb begin
      in_d = in_q;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == in_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= bus.db_thr_i) begin
            in_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (!rst_n_i) cnt_q[i] <= '0;
         else          cnt_q[i] <= cnt_d[i];
      end
   end
`else
   logic unused_db_thr;
   assign unused_db_thr = ^bus.db_thr_i;

   always_comb begin
      in_d = s2_q;
   end
`endif

   // Set beats a coincident clear so an edge is never lost.
   always_comb begin
      irq_d = (irq_q & ~bus.irq_clr_i)
            | (~in_q &  in_d & bus.irq_rise_en_i)
            | ( in_q & ~in_d & bus.irq_fall_en_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pad_out_q <= '0;
         pad_oen_q <= '0;
         pad_ren_q <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         in_q      <= '0;
         irq_q     <= '0;
      end else begin
         pad_out_q <= bus.out_i;
         pad_oen_q <= bus.dir_i;
         pad_ren_q <= bus.pull_en_i;
         s1_q      <= bus.pad_in_i;
         s2_q      <= s1_q;
         in_q      <= in_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.pad_out_o = pad_out_q;
   assign bus.pad_oen_o = pad_oen_q;
   assign bus.pad_ren_o = pad_ren_q;
   assign bus.in_o      = in_q;
   assign bus.irq_o     = irq_q;
   assign bus.irq_any_o = |irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed self-checking bench for gpio_pad_bank; expected latencies follow the debounce build option.
module tb_gpio_pad_bank;

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   passed;

   gpio_pad_bank_if #(.CH_NUM(8), .DB_WIDTH(8)) bus ();

   gpio_pad_bank #(.CH_NUM(8), .DB_WIDTH(8)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat(input int thr);
      return DEB ? 3 + thr : 3;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_irqs();
      bus.irq_clr_i = 8'hFF;
      step(1);
      bus.irq_clr_i = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.dir_i = 8'hFF; bus.out_i = 8'hFF; bus.pull_en_i = 8'hFF;
      bus.pad_in_i = 8'hFF; bus.irq_rise_en_i = 8'hFF;
      step(3);
      checks++; if (bus.pad_out_o !== 8'h00) $display("FAIL reset_pad_out got %h want 00", bus.pad_out_o); else passed++;
      checks++; if (bus.pad_oen_o !== 8'h00) $display("FAIL reset_pad_oen got %h want 00", bus.pad_oen_o); else passed++;
      checks++; if (bus.pad_ren_o !== 8'h00) $display("FAIL reset_pad_ren got %h want 00", bus.pad_ren_o); else passed++;
      checks++; if (bus.in_o !== 8'h00) $display("FAIL reset_in got %h want 00", bus.in_o); else passed++;
      checks++; if (bus.irq_o !== 8'h00 || bus.irq_any_o !== 1'b0)
         $display("FAIL reset_irq got %h/%b want 00/0", bus.irq_o, bus.irq_any_o); else passed++;
      bus.dir_i = 8'h00; bus.out_i = 8'h00; bus.pull_en_i = 8'h00;
      bus.pad_in_i = 8'h00; bus.irq_rise_en_i = 8'h00;
      step(3);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_pad_drive();
      bus.dir_i = 8'hFF; bus.out_i = 8'hA5; bus.pull_en_i = 8'h3C;
      #1;
      checks++; if (bus.pad_oen_o !== 8'h00) $display("FAIL drive_no_comb_path got %h want 00", bus.pad_oen_o); else passed++;
      step(1);
      checks++; if (bus.pad_oen_o !== 8'hFF) $display("FAIL drive_oen got %h want ff", bus.pad_oen_o); else passed++;
      checks++; if (bus.pad_out_o !== 8'hA5) $display("FAIL drive_out got %h want a5", bus.pad_out_o); else passed++;
      checks++; if (bus.pad_ren_o !== 8'h3C) $display("FAIL drive_ren got %h want 3c", bus.pad_ren_o); else passed++;
      bus.dir_i = 8'h00; bus.out_i = 8'h00; bus.pull_en_i = 8'h00;
      step(1);
   endtask

   task automatic test_rise();
      bus.db_thr_i = 8'd4;
      bus.irq_rise_en_i = 8'h01;
      bus.pad_in_i[0] = 1'b1;
      step(lat(4) - 1);
      checks++; if (bus.in_o[0] !== 1'b0 || bus.irq_o[0] !== 1'b0)
         $display("FAIL rise_early got in=%b irq=%b want 0/0", bus.in_o[0], bus.irq_o[0]); else passed++;
      step(1);
      checks++; if (bus.in_o[0] !== 1'b1) $display("FAIL rise_latency got %b want 1", bus.in_o[0]); else passed++;
      checks++; if (bus.irq_o[0] !== 1'b1) $display("FAIL rise_irq got %b want 1", bus.irq_o[0]); else passed++;
      bus.pad_in_i[0] = 1'b0;
      step(lat(4) + 1);
      bus.irq_rise_en_i = 8'h00;
      clear_irqs();
   endtask

   task automatic test_pulse();
      int hi;
      hi = 0;
      bus.irq_rise_en_i = 8'h02;
      bus.pad_in_i[1] = 1'b1;
      // Pulse is sampled high on four edges: one short of a threshold-4 acceptance window.
      for (int i = 0; i < 16; i++) begin
         if (i == 4) bus.pad_in_i[1] = 1'b0;
         step(1);
         if (bus.in_o[1] === 1'b1) hi++;
      end
      checks++; if (hi !== (DEB ? 0 : 4)) $display("FAIL pulse_in_high_edges got %0d want %0d", hi, DEB ? 0 : 4); else passed++;
      checks++; if (bus.irq_o[1] !== (DEB ? 1'b0 : 1'b1))
         $display("FAIL pulse_irq got %b want %b", bus.irq_o[1], DEB ? 1'b0 : 1'b1); else passed++;
      bus.irq_rise_en_i = 8'h00;
      clear_irqs();
   endtask

   task automatic test_fall_clr();
      bus.irq_fall_en_i = 8'h04;
      bus.pad_in_i[2] = 1'b1;
      step(lat(4) + 2);
      checks++; if (bus.in_o[2] !== 1'b1 || bus.irq_o !== 8'h00)
         $display("FAIL fall_setup got in=%b irq=%h want 1/00", bus.in_o[2], bus.irq_o); else passed++;
      bus.pad_in_i[2] = 1'b0;
      step(lat(4) - 1);
      checks++; if (bus.in_o[2] !== 1'b1) $display("FAIL fall_early got %b want 1", bus.in_o[2]); else passed++;
      bus.irq_clr_i[2] = 1'b1;
      step(1);
      bus.irq_clr_i = 8'h00;
      checks++; if (bus.in_o[2] !== 1'b0) $display("FAIL fall_latency got %b want 0", bus.in_o[2]); else passed++;
      checks++; if (bus.irq_o[2] !== 1'b1 || bus.irq_any_o !== 1'b1)
         $display("FAIL fall_set_beats_clr got %b/%b want 1/1", bus.irq_o[2], bus.irq_any_o); else passed++;
      bus.irq_fall_en_i = 8'h00;
      step(3);
      checks++; if (bus.irq_o !== 8'h04) $display("FAIL fall_sticky got %h want 04", bus.irq_o); else passed++;
      bus.irq_clr_i = 8'h04;
      step(1);
      bus.irq_clr_i = 8'h00;
      checks++; if (bus.irq_o !== 8'h00 || bus.irq_any_o !== 1'b0)
         $display("FAIL fall_clear got %h/%b want 00/0", bus.irq_o, bus.irq_any_o); else passed++;
   endtask

   task automatic test_thr_lower();
      bus.db_thr_i = 8'd200;
      bus.irq_rise_en_i = 8'h08;
      bus.pad_in_i[3] = 1'b1;
      // Fifty-two edges leave the channel-3 counter at 50 with the threshold still at 200.
      step(52);
      checks++; if (bus.in_o[3] !== (DEB ? 1'b0 : 1'b1))
         $display("FAIL thr_before got %b want %b", bus.in_o[3], DEB ? 1'b0 : 1'b1); else passed++;
      bus.db_thr_i = 8'd10;
      step(1);
      checks++; if (bus.in_o[3] !== 1'b1 || bus.irq_o[3] !== 1'b1)
         $display("FAIL thr_lowered got in=%b irq=%b want 1/1", bus.in_o[3], bus.irq_o[3]); else passed++;
      bus.db_thr_i = 8'd4;
      bus.pad_in_i[3] = 1'b0;
      bus.irq_rise_en_i = 8'h00;
      step(lat(4) + 1);
      clear_irqs();
   endtask

   task automatic test_loopback();
      bus.dir_i = 8'h40; bus.out_i = 8'h40;
      bus.pad_in_i[6] = 1'b1;
      step(lat(4) - 1);
      checks++; if (bus.in_o[6] !== 1'b0) $display("FAIL loop_early got %b want 0", bus.in_o[6]); else passed++;
      step(1);
      checks++; if (bus.in_o[6] !== 1'b1 || bus.pad_oen_o[6] !== 1'b1)
         $display("FAIL loop_readback got in=%b oen=%b want 1/1", bus.in_o[6], bus.pad_oen_o[6]); else passed++;
      bus.dir_i = 8'h00; bus.out_i = 8'h00; bus.pad_in_i[6] = 1'b0;
      step(lat(4) + 1);
   endtask

   task automatic test_reset_mid();
      bus.irq_rise_en_i = 8'h0F;
      bus.dir_i = 8'hFF; bus.out_i = 8'h5A; bus.pull_en_i = 8'hFF;
      bus.pad_in_i = 8'h0F;
      step(lat(4));
      checks++; if (bus.irq_o !== 8'h0F || bus.in_o !== 8'h0F)
         $display("FAIL rstmid_setup got irq=%h in=%h want 0f/0f", bus.irq_o, bus.in_o); else passed++;
      bus.pad_in_i = 8'h1F;
      step(2);
      rst_n = 1'b0;
      step(1);
      checks++; if (bus.pad_out_o !== 8'h00 || bus.pad_oen_o !== 8'h00 || bus.pad_ren_o !== 8'h00)
         $display("FAIL rstmid_pads got %h/%h/%h want 00/00/00", bus.pad_out_o, bus.pad_oen_o, bus.pad_ren_o); else passed++;
      checks++; if (bus.in_o !== 8'h00 || bus.irq_o !== 8'h00 || bus.irq_any_o !== 1'b0)
         $display("FAIL rstmid_state got in=%h irq=%h any=%b want 00/00/0", bus.in_o, bus.irq_o, bus.irq_any_o); else passed++;
      rst_n = 1'b1;
      bus.pad_in_i = 8'h00;
      bus.irq_fall_en_i = 8'hFF;
      step(lat(4) + 2);
      checks++; if (bus.irq_o !== 8'h00 || bus.in_o !== 8'h00)
         $display("FAIL rstmid_no_irq got irq=%h in=%h want 00/00", bus.irq_o, bus.in_o); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n = 1'b0;
      bus.dir_i = '0; bus.out_i = '0; bus.pull_en_i = '0; bus.db_thr_i = '0;
      bus.irq_rise_en_i = '0; bus.irq_fall_en_i = '0; bus.irq_clr_i = '0; bus.pad_in_i = '0;
      test_reset();
      test_pad_drive();
      test_rise();
      test_pulse();
      test_fall_clr();
      test_thr_lower();
      test_loopback();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
